// File: rtl/vector_issue_sequencer.sv
// -----------------------------------------------------------------------------
// vector_issue_sequencer
//   Front end of the vector register file. Accepts one decoded vector op and
//   walks it beat by beat (4 elements per beat, ceil(vl/4) beats). It drives the
//   register-file read addresses and, after PE_LATENCY cycles, the write-back
//   address and partial-write count of each beat.
//
// Ports
//   clk, reset (sync, active-high)
//   instr_valid / instr_ready           : op handshake (ready only in IDLE)
//   vs1_base, vs2_base, vd_base [4:0]   : register group bases
//   vsew_in [1:0], vl_in [5:0]          : element width code, element count
//   widening_in, uses_vs3_in            : 2*SEW destination, vd read as operand
//   hold                                : downstream stall, freezes everything
//   vs1_addr, vs2_addr [4:0]            : read addresses of the current beat
//   vd_addr [4:0]                       : write address when write=1, else vs3 read
//   vsew [1:0], widening_op             : captured op configuration
//   operand_valid, write                : beat issue / write strobes
//   elements_to_write [1:0]             : 0 = all 4, 1..3 = partial last beat
//   busy, done, illegal                 : in flight / completion / reject pulses
//
// Optional feature macro: VSEQ_PERF_CNT_EN adds perf_beats[15:0] and
// perf_holds[15:0] (saturating, cleared only by reset).
// -----------------------------------------------------------------------------
module vector_issue_sequencer #(
  parameter int VLEN       = 32,
  parameter int LMUL_MAX   = 8,
  parameter int PE_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [4:0] vs1_base,
  input  logic [4:0] vs2_base,
  input  logic [4:0] vd_base,
  input  logic [1:0] vsew_in,
  input  logic [5:0] vl_in,
  input  logic       widening_in,
  input  logic       uses_vs3_in,
  input  logic       hold,
  output logic [4:0] vs1_addr,
  output logic [4:0] vs2_addr,
  output logic [4:0] vd_addr,
  output logic [1:0] vsew,
  output logic       widening_op,
  output logic       operand_valid,
  output logic       write,
  output logic [1:0] elements_to_write,
  output logic       busy,
  output logic       done,
  output logic       illegal
`ifdef VSEQ_PERF_CNT_EN
  ,
  output logic [15:0] perf_beats,
  output logic [15:0] perf_holds
`endif
);

  // VLMAX for 8-bit elements; shifted right by vsew for wider elements.
  localparam logic [6:0] VLMAX8 = 7'(VLEN * LMUL_MAX / 8);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_REJECT = 2'd3
  } state_t;

  state_t      state_r, state_nx_s;

  logic [1:0]  vsew_r;
  logic        widening_r;
  logic        uses_vs3_r;
  logic [1:0]  vl_lsb_r;
  logic [3:0]  last_idx_r;
  logic [3:0]  beat_r;
  logic [4:0]  vs1_rd_r, vs2_rd_r, vd_rd_r;

  logic        pipe_v_r   [PE_LATENCY];
  logic [4:0]  pipe_vd_r  [PE_LATENCY];
  logic [1:0]  pipe_etw_r [PE_LATENCY];

  logic        accept_s, issue_s, last_s, pipe_empty_s, illegal_in_s;
  logic        done_s, illegal_s, ready_s, busy_s, write_s;
  logic [6:0]  vlmax_s;
  logic [4:0]  src_stride_s, dst_stride_s;

  assign vlmax_s      = VLMAX8 >> vsew_in;
  assign illegal_in_s = (vsew_in == 2'd3) | (widening_in & (vsew_in == 2'd2)) |
                        ({1'b0, vl_in} > vlmax_s);
  assign accept_s     = instr_valid & (state_r == S_IDLE) & ~reset;
  assign last_s       = (beat_r == last_idx_r);
  // Widened destinations advance twice as fast through the register file.
  assign src_stride_s = 5'd1 << vsew_r;
  assign dst_stride_s = 5'd1 << (vsew_r + {1'b0, widening_r});

  // Pipe is empty when no beat is still waiting for its write-back slot.
  always_comb begin
    pipe_empty_s = 1'b1;
    for (int i = 0; i < PE_LATENCY; i++) begin
      pipe_empty_s = pipe_empty_s & ~pipe_v_r[i];
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nx_s = state_r;
    issue_s    = 1'b0;
    done_s     = 1'b0;
    illegal_s  = 1'b0;
    ready_s    = 1'b0;
    busy_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        ready_s = 1'b1;
        if (accept_s) begin
          if (illegal_in_s) begin
            state_nx_s = S_REJECT;
          end else if (vl_in == 6'd0) begin
            state_nx_s = S_DRAIN;
          end else begin
            state_nx_s = S_ISSUE;
          end
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        busy_s  = 1'b1;
        // A vs3 op shares the vd port, so its next beat waits for the write.
        issue_s = ~hold & (~uses_vs3_r | pipe_empty_s);
        if (issue_s && last_s) begin
          state_nx_s = S_DRAIN;
        end else begin
          state_nx_s = S_ISSUE;
        end
      end
      S_DRAIN: begin
        busy_s = 1'b1;
        if (~hold && pipe_empty_s) begin
          done_s     = 1'b1;
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_DRAIN;
        end
      end
      S_REJECT: begin
        if (~hold) begin
          illegal_s  = 1'b1;
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_REJECT;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Op capture and per-beat address stepping.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsew_r     <= 2'd0;
      widening_r <= 1'b0;
      uses_vs3_r <= 1'b0;
      vl_lsb_r   <= 2'd0;
      last_idx_r <= 4'd0;
      beat_r     <= 4'd0;
      vs1_rd_r   <= 5'd0;
      vs2_rd_r   <= 5'd0;
      vd_rd_r    <= 5'd0;
    end else if (accept_s) begin
      vsew_r     <= vsew_in;
      widening_r <= widening_in;
      uses_vs3_r <= uses_vs3_in;
      vl_lsb_r   <= vl_in[1:0];
      last_idx_r <= 4'((vl_in - 6'd1) >> 2);
      beat_r     <= 4'd0;
      vs1_rd_r   <= vs1_base;
      vs2_rd_r   <= vs2_base;
      vd_rd_r    <= vd_base;
    end else if (issue_s) begin
      beat_r   <= beat_r + 4'd1;
      vs1_rd_r <= vs1_rd_r + src_stride_s;
      vs2_rd_r <= vs2_rd_r + src_stride_s;
      vd_rd_r  <= vd_rd_r + dst_stride_s;
    end
  end

  // Write-back delay line; its last stage is the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PE_LATENCY; i++) begin
        pipe_v_r[i]   <= 1'b0;
        pipe_vd_r[i]  <= 5'd0;
        pipe_etw_r[i] <= 2'd0;
      end
    end else if (~hold) begin
      pipe_v_r[0]   <= issue_s;
      pipe_vd_r[0]  <= vd_rd_r;
      pipe_etw_r[0] <= (issue_s && last_s) ? vl_lsb_r : 2'd0;
      for (int i = 1; i < PE_LATENCY; i++) begin
        pipe_v_r[i]   <= pipe_v_r[i-1];
        pipe_vd_r[i]  <= pipe_vd_r[i-1];
        pipe_etw_r[i] <= pipe_etw_r[i-1];
      end
    end
  end

  // Strobes are masked while held or in reset so nothing leaks out of a frozen pipe.
  assign write_s           = pipe_v_r[PE_LATENCY-1] & ~hold & ~reset;
  assign write             = write_s;
  assign operand_valid     = issue_s & ~reset;
  assign done              = done_s & ~reset;
  assign illegal           = illegal_s & ~reset;
  assign instr_ready       = ready_s & ~reset;
  assign busy              = busy_s & ~reset;
  assign vs1_addr          = vs1_rd_r;
  assign vs2_addr          = vs2_rd_r;
  assign vd_addr           = write_s ? pipe_vd_r[PE_LATENCY-1] : vd_rd_r;
  assign elements_to_write = pipe_etw_r[PE_LATENCY-1];
  assign vsew              = vsew_r;
  assign widening_op       = widening_r;

`ifdef VSEQ_PERF_CNT_EN
  logic [15:0] perf_beats_r, perf_holds_r;

  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_beats_r <= 16'd0;
      perf_holds_r <= 16'd0;
    end else begin
      if (issue_s && (perf_beats_r != 16'hFFFF)) begin
        perf_beats_r <= perf_beats_r + 16'd1;
      end
      if (hold && busy_s && (perf_holds_r != 16'hFFFF)) begin
        perf_holds_r <= perf_holds_r + 16'd1;
      end
    end
  end

  assign perf_beats = perf_beats_r;
  assign perf_holds = perf_holds_r;
`endif

endmodule

// File: tb/tb_vector_issue_sequencer.sv
// Scoreboard bench: the driver pushes the expected beats, writes and completion
// of every op, computed from element-count arithmetic; a monitor pops them as the
// DUT strobes. Timing is expressed as the count of un-held cycles after accept.
module tb_vector_issue_sequencer;
  localparam int PE_LAT = 1;
  localparam int VLEN_TB = 32;
  localparam int LMUL_TB = 8;

  logic       clk;
  logic       reset, instr_valid, instr_ready;
  logic [4:0] vs1_base, vs2_base, vd_base;
  logic [1:0] vsew_in;
  logic [5:0] vl_in;
  logic       widening_in, uses_vs3_in, hold;
  logic [4:0] vs1_addr, vs2_addr, vd_addr;
  logic [1:0] vsew;
  logic       widening_op, operand_valid, write;
  logic [1:0] elements_to_write;
  logic       busy, done, illegal;

  vector_issue_sequencer #(.VLEN(32), .LMUL_MAX(8), .PE_LATENCY(PE_LAT)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .vs1_base(vs1_base), .vs2_base(vs2_base), .vd_base(vd_base), .vsew_in(vsew_in),
    .vl_in(vl_in), .widening_in(widening_in), .uses_vs3_in(uses_vs3_in), .hold(hold),
    .vs1_addr(vs1_addr), .vs2_addr(vs2_addr), .vd_addr(vd_addr), .vsew(vsew),
    .widening_op(widening_op), .operand_valid(operand_valid), .write(write),
    .elements_to_write(elements_to_write), .busy(busy), .done(done), .illegal(illegal)
  );

  typedef struct { int vs1; int vs2; int vd; int n; int sew; int wid; } beat_t;
  typedef struct { int vd; int etw; int n; } wr_t;
  typedef struct { int illegal; int n; } fin_t;

  beat_t beat_q[$];
  wr_t   wr_q[$];
  fin_t  fin_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit in_op    = 1'b0;
  int act_n    = 0;
  bit hold_force   = 1'b0;
  bit hold_rand_en = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: beats/writes/completion from vl, sew and the op flags.
  task automatic push_expect(input int b1, input int b2, input int bd, input int sew,
                             input int vl, input int wid, input int vs3);
    int vlmax, nb, gap;
    beat_t b;
    wr_t   w;
    fin_t  f;
    vlmax = (VLEN_TB * LMUL_TB) / (8 << sew);
    if (sew == 3 || (wid != 0 && sew == 2) || vl > vlmax) begin
      f.illegal = 1; f.n = 1; fin_q.push_back(f);
      return;
    end
    f.illegal = 0;
    if (vl == 0) begin
      f.n = 1; fin_q.push_back(f);
      return;
    end
    nb  = (vl + 3) / 4;
    gap = (vs3 != 0) ? PE_LAT + 1 : 1;
    for (int k = 0; k < nb; k++) begin
      b.vs1 = (b1 + k * (1 << sew)) % 32;
      b.vs2 = (b2 + k * (1 << sew)) % 32;
      b.vd  = (bd + k * (1 << (sew + wid))) % 32;
      b.n   = 1 + k * gap;
      b.sew = sew;
      b.wid = wid;
      beat_q.push_back(b);
      w.vd  = b.vd;
      w.etw = (k == nb - 1) ? vl % 4 : 0;
      w.n   = b.n + PE_LAT;
      wr_q.push_back(w);
    end
    f.n = 1 + (nb - 1) * gap + PE_LAT + 1;
    fin_q.push_back(f);
  endtask

  // Hold generator: sole driver of hold.
  initial begin
    hold = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      hold = hold_force | (hold_rand_en && ($urandom_range(0, 3) == 0));
    end
  end

  // Monitor / scoreboard.
  initial begin
    beat_t b;
    wr_t   w;
    fin_t  f;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_op = 1'b0;
        chk("reset_quiet", int'({operand_valid, write, done, illegal, instr_ready, busy}), 0);
      end else begin
        if (in_op && !hold) act_n++;
        chk("instr_ready", int'(instr_ready), int'(!in_op));
        if (!in_op) chk("busy_idle", int'(busy), 0);
        else if (fin_q.size() > 0) chk("busy_op", int'(busy), int'(fin_q[0].illegal == 0));
        if (operand_valid) begin
          if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
          else begin
            b = beat_q.pop_front();
            chk("beat_vs1", int'(vs1_addr), b.vs1);
            chk("beat_vs2", int'(vs2_addr), b.vs2);
            if (!write) chk("beat_vd_read", int'(vd_addr), b.vd);
            chk("beat_cycle", act_n, b.n);
            chk("beat_vsew", int'(vsew), b.sew);
            chk("beat_widening", int'(widening_op), b.wid);
          end
        end
        if (write) begin
          if (wr_q.size() == 0) chk("write_unexpected", 1, 0);
          else begin
            w = wr_q.pop_front();
            chk("write_vd", int'(vd_addr), w.vd);
            chk("write_etw", int'(elements_to_write), w.etw);
            chk("write_cycle", act_n, w.n);
          end
        end
        if (done || illegal) begin
          if (fin_q.size() == 0) chk("finish_unexpected", 1, 0);
          else begin
            f = fin_q.pop_front();
            chk("finish_illegal", int'(illegal), f.illegal);
            chk("finish_done", int'(done), int'(f.illegal == 0));
            chk("finish_cycle", act_n, f.n);
            chk("finish_leftover", beat_q.size() + wr_q.size(), 0);
          end
          in_op = 1'b0;
        end
        if (instr_valid && instr_ready) begin
          in_op = 1'b1;
          act_n = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int t;
    for (t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (!in_op && fin_q.size() == 0) break;
    end
    if (t == 2000) chk("completion_timeout", 0, 1);
  endtask

  // Issue one op; optionally force hold for hlen cycles starting at T+hat.
  task automatic run_op(input int b1, input int b2, input int bd, input int sew, input int vl,
                        input int wid, input int vs3, input int hat, input int hlen);
    int t;
    @(posedge clk);
    #1;
    push_expect(b1, b2, bd, sew, vl, wid, vs3);
    vs1_base = 5'(b1); vs2_base = 5'(b2); vd_base = 5'(bd);
    vsew_in = 2'(sew); vl_in = 6'(vl); widening_in = 1'(wid); uses_vs3_in = 1'(vs3);
    instr_valid = 1'b1;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (instr_ready) break;
    end
    if (t == 200) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    if (hat > 0) begin
      repeat (hat - 1) @(posedge clk);
      #1 hold_force = 1'b1;
      repeat (hlen) @(posedge clk);
      #1 hold_force = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    int sew, wid, vl;
    reset = 1'b1; instr_valid = 1'b0;
    vs1_base = 5'd0; vs2_base = 5'd0; vd_base = 5'd0;
    vsew_in = 2'd0; vl_in = 6'd0; widening_in = 1'b0; uses_vs3_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", int'(instr_ready), 1);
    chk("post_reset_addr", int'({vs1_addr, vs2_addr, vd_addr}), 0);
    chk("post_reset_cfg", int'({vsew, widening_op, elements_to_write}), 0);

    run_op(8, 16, 24, 0, 10, 0, 0, 0, 0);   // 3 beats, last partial (2)
    run_op(4, 12, 8, 1, 6, 1, 0, 0, 0);     // widening: vd stride 4
    run_op(3, 5, 16, 0, 8, 0, 1, 0, 0);     // vs3 serialised beats
    run_op(0, 8, 20, 2, 8, 0, 0, 2, 2);     // hold over two cycles
    run_op(1, 2, 3, 0, 0, 0, 0, 0, 0);      // vl=0
    run_op(1, 2, 3, 2, 4, 1, 0, 0, 0);      // widening 32b illegal
    run_op(1, 2, 3, 0, 33, 0, 0, 0, 0);     // vl > VLMAX
    run_op(1, 2, 3, 3, 4, 0, 0, 0, 0);      // vsew=3 illegal
    run_op(30, 31, 28, 2, 8, 0, 0, 0, 0);   // address wrap
    run_op(0, 0, 0, 0, 32, 0, 0, 0, 0);     // full VLMAX

    // Reset two cycles into a long op: nothing more may come out.
    @(posedge clk);
    #1;
    push_expect(0, 8, 16, 0, 32, 0, 0);
    vs1_base = 5'd0; vs2_base = 5'd8; vd_base = 5'd16;
    vsew_in = 2'd0; vl_in = 6'd32; widening_in = 1'b0; uses_vs3_in = 1'b0;
    instr_valid = 1'b1;
    @(negedge clk);
    chk("abort_accept_ready", int'(instr_ready), 1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    beat_q.delete(); wr_q.delete(); fin_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", int'(instr_ready), 1);
    chk("abort_busy_after", int'(busy), 0);
    repeat (20) @(negedge clk);

    hold_rand_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sew = $urandom_range(0, 3);
      wid = $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0) vl = $urandom_range(0, 63);
      else vl = $urandom_range(0, 32 >> (sew == 3 ? 0 : sew + wid));
      run_op($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             sew, vl, wid, $urandom_range(0, 1), 0, 0);
    end
    hold_rand_en = 1'b0;
    wait_idle();
    chk("final_queues_empty", beat_q.size() + wr_q.size() + fin_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
